// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
//   Lets two requesters share one sequential multiplier. In IDLE a requester is
//   chosen (round-robin when both ask) and its operands are latched. The
//   multiplier start is then pulsed, the bench-side product is awaited and
//   returned to the winner. A watchdog ends the transaction with err=1 if the
//   multiplier never reports valid.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   req0/a0/b0        requester 0 request (held until gnt0) and operands
//   req1/a1/b1        requester 1 request (held until gnt1) and operands
//   gnt0/gnt1         1-cycle pulse: operands of that requester captured
//   done0/done1       1-cycle pulse: res/err valid for that requester
//   res, err          last product (held until next done), watchdog abort flag
//   busy              high whenever the FSM is not in IDLE
//   m_start/m_a/m_b   multiplier start pulse and operands
//   m_out/m_valid     multiplier product and valid (level or pulse)
module mult_share_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0,
  input  logic [N-1:0]   a0,
  input  logic [N-1:0]   b0,
  input  logic           req1,
  input  logic [N-1:0]   a1,
  input  logic [N-1:0]   b1,
  output logic           gnt0,
  output logic           gnt1,
  output logic           done0,
  output logic           done1,
  output logic [2*N-1:0] res,
  output logic           err,
  output logic           busy,
  output logic           m_start,
  output logic [N-1:0]   m_a,
  output logic [N-1:0]   m_b,
  input  logic [2*N-1:0] m_out,
  input  logic           m_valid
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  logic [1:0]     state_reg;
  logic [TW-1:0]  timer_reg;
  logic           rr_reg;      // requester preferred when both ask
  logic           owner_reg;   // requester of the transaction in flight
  logic           m_valid_q_reg;
  logic           gnt0_reg, gnt1_reg, done0_reg, done1_reg;
  logic [2*N-1:0] res_reg;
  logic           err_reg, busy_reg, m_start_reg;
  logic [N-1:0]   m_a_reg, m_b_reg;

  // Requester 0 wins when it is alone or when the pointer favours it.
  logic pick0;
  logic valid_rise;
  assign pick0      = req0 && (!req1 || !rr_reg);
  assign valid_rise = m_valid && !m_valid_q_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      timer_reg     <= '0;
      rr_reg        <= 1'b0;
      owner_reg     <= 1'b0;
      m_valid_q_reg <= 1'b0;
      gnt0_reg      <= 1'b0;
      gnt1_reg      <= 1'b0;
      done0_reg     <= 1'b0;
      done1_reg     <= 1'b0;
      res_reg       <= '0;
      err_reg       <= 1'b0;
      busy_reg      <= 1'b0;
      m_start_reg   <= 1'b0;
      m_a_reg       <= '0;
      m_b_reg       <= '0;
    end else begin
      // Pulse outputs default low; the edge detector tracks valid in every state.
      gnt0_reg      <= 1'b0;
      gnt1_reg      <= 1'b0;
      done0_reg     <= 1'b0;
      done1_reg     <= 1'b0;
      m_start_reg   <= 1'b0;
      m_valid_q_reg <= m_valid;
      case (state_reg)
        S_IDLE: begin
          if (pick0) begin
            m_a_reg   <= a0;
            m_b_reg   <= b0;
            owner_reg <= 1'b0;
            gnt0_reg  <= 1'b1;
            busy_reg  <= 1'b1;
            state_reg <= S_ISSUE;
          end else if (req1) begin
            m_a_reg   <= a1;
            m_b_reg   <= b1;
            owner_reg <= 1'b1;
            gnt1_reg  <= 1'b1;
            busy_reg  <= 1'b1;
            state_reg <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          m_start_reg <= 1'b1;
          timer_reg   <= '0;
          state_reg   <= S_WAIT;
        end
        S_WAIT: begin
          // Completion is checked first so it wins over a same-cycle timeout.
          if (valid_rise) begin
            res_reg   <= m_out;
            err_reg   <= 1'b0;
            done0_reg <= !owner_reg;
            done1_reg <= owner_reg;
            state_reg <= S_DONE;
          end else if (timer_reg == TIMER_LAST) begin
            res_reg   <= '0;
            err_reg   <= 1'b1;
            done0_reg <= !owner_reg;
            done1_reg <= owner_reg;
            state_reg <= S_DONE;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        default: begin  // S_DONE: done is visible now; hand priority over
          rr_reg    <= !owner_reg;
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt0    = gnt0_reg;
  assign gnt1    = gnt1_reg;
  assign done0   = done0_reg;
  assign done1   = done1_reg;
  assign res     = res_reg;
  assign err     = err_reg;
  assign busy    = busy_reg;
  assign m_start = m_start_reg;
  assign m_a     = m_a_reg;
  assign m_b     = m_b_reg;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter
//   Directed and randomized transactions against mult_share_arbiter with a
//   behavioural multiplier stub (programmable valid delay / hold length / never).
module tb_mult_share_arbiter;
  localparam int N  = 4;
  localparam int TO = 32;

  logic clk = 1'b0;
  logic rst;
  logic req0, req1;
  logic [N-1:0] a0, b0, a1, b1;
  logic gnt0, gnt1, done0, done1, err, busy, m_start;
  logic [2*N-1:0] res, m_out;
  logic [N-1:0] m_a, m_b;
  logic m_valid;

  always #5 clk = ~clk;

  mult_share_arbiter #(.N(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .res(res), .err(err), .busy(busy),
    .m_start(m_start), .m_a(m_a), .m_b(m_b),
    .m_out(m_out), .m_valid(m_valid)
  );

  int checks = 0;
  int errors = 0;

  // Multiplier stub: valid rises stub_delay cycles after start is seen, stays
  // high for stub_hold cycles; stub_never suppresses valid entirely.
  int  stub_delay = 5;
  int  stub_hold  = 1;
  bit  stub_never = 1'b0;
  bit  pend = 1'b0;
  int  cnt = 0;
  int  hold_left = 0;
  logic [2*N-1:0] prod;

  initial begin
    m_valid = 1'b0;
    m_out   = 8'h5A;
  end

  always @(negedge clk) begin
    if (hold_left > 0) begin
      hold_left = hold_left - 1;
      if (hold_left == 0) m_valid = 1'b0;
    end
    if (m_start && !stub_never) begin
      pend = 1'b1;
      cnt  = stub_delay;
      prod = (2*N)'(m_a) * (2*N)'(m_b);
    end
    if (pend) begin
      if (cnt == 0) begin
        m_valid   = 1'b1;
        m_out     = prod;
        hold_left = stub_hold;
        pend      = 1'b0;
      end else begin
        cnt = cnt - 1;
      end
    end
  end

  // Event counters sampled mid-cycle.
  int start_cnt = 0, gnt1_cnt = 0, done_cnt = 0, overlap_cnt = 0;
  always @(negedge clk) begin
    if (m_start) start_cnt++;
    if (gnt1) gnt1_cnt++;
    if (done0 || done1) done_cnt++;
    if (done0 && done1) overlap_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Reference model state: which requester wins when both ask.
  bit rr_m = 1'b0;

  function automatic int pick(input bit r0, input bit r1);
    if (r0 && r1) return int'(rr_m);
    return r0 ? 0 : 1;
  endfunction

  // One complete transaction: wait for the grant, check it, then wait for the
  // result and compare against a*b (or the abort value) and the expected latency.
  task automatic serve(input int owner, input logic [N-1:0] ea, input logic [N-1:0] eb,
                       input int d, input int hold, input bit never, input bit drop);
    int n, lat, starts0;
    bit exp_err;
    logic [2*N-1:0] exp_res;
    stub_delay = d;
    stub_hold  = hold;
    stub_never = never;
    exp_err = never || (d > TO - 1);
    exp_res = exp_err ? '0 : (2*N)'(ea) * (2*N)'(eb);
    starts0 = start_cnt;
    n = 0;
    while (!(gnt0 || gnt1) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("gnt_wait", 32'(n < 60), 32'd1);
    check("gnt_owner", {30'd0, gnt1, gnt0}, (owner == 1) ? 32'd2 : 32'd1);
    check("busy_at_gnt", 32'(busy), 32'd1);
    if (drop) begin
      if (owner == 1) req1 = 1'b0; else req0 = 1'b0;
    end
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(done0 || done1) && lat < 80);
    check("done_owner", {30'd0, done1, done0}, (owner == 1) ? 32'd2 : 32'd1);
    check("res", 32'(res), 32'(exp_res));
    check("err", 32'(err), 32'(exp_err));
    check("latency", 32'(lat), exp_err ? 32'(TO + 1) : 32'(d + 2));
    check("start_once", 32'(start_cnt - starts0), 32'd1);
    $display("txn owner=%0d a=%0d b=%0d delay=%0d never=%0d -> res=%0d err=%0d lat=%0d",
             owner, ea, eb, d, never, res, err, lat);
    rr_m = (owner == 1) ? 1'b0 : 1'b1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_pulses"}, {27'd0, gnt0, gnt1, done0, done1, m_start}, 32'd0);
    check({tag, "_res"}, 32'(res), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_mab"}, {24'd0, m_a, m_b}, 32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rr_m = 1'b0;
  endtask

  initial begin
    int n, dc0, gc0, sc0;
    bit r0, r1;
    int first, d, hold;
    bit never;
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("idle_noreq");

    // Single request 2x2.
    a0 = 4'd2; b0 = 4'd2; req0 = 1'b1;
    serve(0, 4'd2, 4'd2, 5, 1, 1'b0, 1'b1);

    // Both rise right after reset: requester 0 first, then 1.
    pulse_reset();
    a0 = 4'd3; b0 = 4'd5; a1 = 4'd7; b1 = 4'd9;
    req0 = 1'b1; req1 = 1'b1;
    serve(pick(1, 1), 4'd3, 4'd5, 5, 1, 1'b0, 1'b1);
    serve(pick(0, 1), 4'd7, 4'd9, 5, 1, 1'b0, 1'b1);

    // Both held for four transactions: grants alternate.
    a0 = 4'd4; b0 = 4'd6; a1 = 4'd5; b1 = 4'd3;
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      first = pick(1, 1);
      check("alternation", 32'(first), 32'(i % 2));
      if (first == 0) serve(0, 4'd4, 4'd6, 5, 1, 1'b0, 1'b0);
      else            serve(1, 4'd5, 4'd3, 5, 1, 1'b0, 1'b0);
    end
    req0 = 1'b0; req1 = 1'b0;
    check("no_done_overlap", 32'(overlap_cnt), 32'd0);

    // A request dropped before its grant is never served.
    gc0 = gnt1_cnt;
    a0 = 4'd1; b0 = 4'd9; req0 = 1'b1;
    n = 0;
    while (!gnt0 && n < 20) begin @(negedge clk); n++; end
    check("cancel_gnt0", 32'(gnt0), 32'd1);
    req0 = 1'b0; req1 = 1'b1;
    repeat (3) @(negedge clk);
    req1 = 1'b0;
    n = 0;
    while (!done0 && n < 40) begin @(negedge clk); n++; end
    check("cancel_done0", 32'(done0), 32'd1);
    check("cancel_res", 32'(res), 32'd9);
    rr_m = 1'b1;
    repeat (8) @(negedge clk);
    check("cancel_no_gnt1", 32'(gnt1_cnt - gc0), 32'd0);
    check("cancel_idle", 32'(busy), 32'd0);

    // Watchdog: valid never arrives.
    a0 = 4'd6; b0 = 4'd7; req0 = 1'b1;
    serve(pick(1, 0), 4'd6, 4'd7, 0, 1, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    check("timeout_back_idle", 32'(busy), 32'd0);

    // Level-held valid counted once.
    dc0 = done_cnt;
    a0 = 4'd15; b0 = 4'd15; req0 = 1'b1;
    serve(pick(1, 0), 4'd15, 4'd15, 5, 3, 1'b0, 1'b1);
    repeat (8) @(negedge clk);
    check("level_valid_one_done", 32'(done_cnt - dc0), 32'd1);

    // Completion on the last watchdog cycle wins; one later is an abort.
    a1 = 4'd11; b1 = 4'd13; req1 = 1'b1;
    serve(pick(0, 1), 4'd11, 4'd13, TO - 1, 1, 1'b0, 1'b1);
    a1 = 4'd12; b1 = 4'd10; req1 = 1'b1;
    serve(pick(0, 1), 4'd12, 4'd10, TO, 1, 1'b0, 1'b1);
    repeat (4) @(negedge clk);

    // Async reset in the middle of WAIT.
    a0 = 4'd9; b0 = 4'd8; req0 = 1'b1;
    stub_never = 1'b1;
    n = 0;
    while (!gnt0 && n < 20) begin @(negedge clk); n++; end
    check("rstwait_gnt0", 32'(gnt0), 32'd1);
    req0 = 1'b0;
    repeat (5) @(negedge clk);
    check("rstwait_busy_before", 32'(busy), 32'd1);
    dc0 = done_cnt;
    sc0 = start_cnt;
    #2 rst = 1'b1;
    #1 check_idle_outputs("rst_midwait");
    @(negedge clk);
    rst = 1'b0;
    rr_m = 1'b0;
    repeat (40) @(negedge clk);
    check("rst_no_done", 32'(done_cnt - dc0), 32'd0);
    check("rst_no_restart", 32'(start_cnt - sc0), 32'd0);
    a1 = 4'd3; b1 = 4'd3; a0 = 4'd2; b0 = 4'd7;
    req0 = 1'b1; req1 = 1'b1;
    serve(pick(1, 1), 4'd2, 4'd7, 4, 1, 1'b0, 1'b1);
    serve(pick(0, 1), 4'd3, 4'd3, 4, 1, 1'b0, 1'b1);

    // Randomized transactions.
    for (int i = 0; i < 12; i++) begin
      r0 = 1'b0; r1 = 1'b0;
      case ($urandom_range(1, 3))
        1: r0 = 1'b1;
        2: r1 = 1'b1;
        default: begin r0 = 1'b1; r1 = 1'b1; end
      endcase
      a0 = 4'($urandom); b0 = 4'($urandom);
      a1 = 4'($urandom); b1 = 4'($urandom);
      req0 = r0; req1 = r1;
      for (int k = 0; k < 2; k++) begin
        if (k == 1 && !(r0 && r1)) break;
        case ($urandom_range(0, 9))
          6:       begin d = TO - 1; never = 1'b0; end
          7:       begin d = TO;     never = 1'b0; end
          8:       begin d = 0;      never = 1'b1; end
          9:       begin d = $urandom_range(0, 30); never = 1'b0; end
          default: begin d = $urandom_range(0, 8);  never = 1'b0; end
        endcase
        hold = (d >= TO - 1 || never) ? 1 : $urandom_range(1, 3);
        first = pick(req0, req1);
        if (first == 0) serve(0, a0, b0, d, hold, never, 1'b1);
        else            serve(1, a1, b1, d, hold, never, 1'b1);
      end
      repeat ($urandom_range(0, 4)) @(negedge clk);
    end
    check("final_no_overlap", 32'(overlap_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute backstop so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
